// File: rtl/uart_cmd_parser.sv
// Framed command parser behind a UART receiver: SOF | CMD | DATA_H | DATA_L | CHK -> one valid/ready command.
// Define UART_CMD_TIMEOUT_EN to build the inter-byte timeout; otherwise o_err_timeout is tied low.
module uart_cmd_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'h55,
  parameter int         CLOCK_FREQ     = 50_000_000,
  parameter int         TIMEOUT_CYCLES = 104_160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_wr,
  output logic [6:0]  o_cmd_addr,
  output logic [15:0] o_cmd_wdata,
  output logic        o_err_chk,
  output logic        o_err_overrun,
  output logic        o_err_timeout,
  output logic [2:0]  o_dbg_state
);

  // Command port: o_cmd_valid is held with o_cmd_* stable until the cycle where
  // o_cmd_valid && i_cmd_ready; the command is consumed at that clock edge.
  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_CMD   = 3'd1,
    S_DH    = 3'd2,
    S_DL    = 3'd3,
    S_CHK   = 3'd4,
    S_ISSUE = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2 || CLOCK_FREQ < 1) begin : g_param_chk
    $error("uart_cmd_parser: TIMEOUT_CYCLES must be >= 2 and CLOCK_FREQ positive");
  end

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_sum, w_sum_nxt;
  logic        r_wr, w_wr_nxt;
  logic [6:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_dh, w_dh_nxt;
  logic [7:0]  r_dl, w_dl_nxt;
  logic        r_err_chk, w_err_chk_nxt;
  logic        r_err_ovr, w_err_ovr_nxt;
  logic        r_err_tmo, w_err_tmo_nxt;
  logic        w_tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_in_frame;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_DH) ||
                      (r_state == S_DL)  || (r_state == S_CHK);

  // A byte strobe in the expiry cycle wins: the hit is masked and the counter restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_tmo_cnt <= '0;
    else if (i_rx_valid || !w_in_frame) r_tmo_cnt <= '0;
    else                                r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  assign w_tmo_hit = w_in_frame && !i_rx_valid &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HUNT;
      r_sum     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_dh      <= '0;
      r_dl      <= '0;
      r_err_chk <= 1'b0;
      r_err_ovr <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sum     <= w_sum_nxt;
      r_wr      <= w_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_dh      <= w_dh_nxt;
      r_dl      <= w_dl_nxt;
      r_err_chk <= w_err_chk_nxt;
      r_err_ovr <= w_err_ovr_nxt;
      r_err_tmo <= w_err_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sum_nxt     = r_sum;
    w_wr_nxt      = r_wr;
    w_addr_nxt    = r_addr;
    w_dh_nxt      = r_dh;
    w_dl_nxt      = r_dl;
    w_err_chk_nxt = 1'b0;
    w_err_ovr_nxt = 1'b0;
    w_err_tmo_nxt = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (i_rx_valid && (i_rx_data == SOF_BYTE)) begin
          w_sum_nxt   = '0;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (i_rx_valid) begin
          w_wr_nxt    = i_rx_data[7];
          w_addr_nxt  = i_rx_data[6:0];
          w_sum_nxt   = i_rx_data;
          w_state_nxt = S_DH;
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_HUNT;
        end
      end
      S_DH: begin
        if (i_rx_valid) begin
          w_dh_nxt    = i_rx_data;
          w_sum_nxt   = r_sum + i_rx_data;
          w_state_nxt = S_DL;
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_HUNT;
        end
      end
      S_DL: begin
        if (i_rx_valid) begin
          w_dl_nxt    = i_rx_data;
          w_sum_nxt   = r_sum + i_rx_data;
          w_state_nxt = S_CHK;
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_HUNT;
        end
      end
      S_CHK: begin
        // A bad checksum byte is never reconsidered as a start of frame.
        if (i_rx_valid) begin
          if (i_rx_data == r_sum) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_err_chk_nxt = 1'b1;
            w_state_nxt   = S_HUNT;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_HUNT;
        end
      end
      S_ISSUE: begin
        w_err_ovr_nxt = i_rx_valid;
        if (i_cmd_ready) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  assign o_cmd_valid   = (r_state == S_ISSUE);
  assign o_cmd_wr      = r_wr;
  assign o_cmd_addr    = r_addr;
  assign o_cmd_wdata   = {r_dh, r_dl};
  assign o_err_chk     = r_err_chk;
  assign o_err_overrun = r_err_ovr;
  assign o_err_timeout = r_err_tmo;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: byte-level frame model feeds expected queues,
// a negedge monitor checks commands and error pulses as the DUT presents them.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int T   = 100;
  localparam int INF = 32'h7fff_ffff;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam logic [1:0] K_CHK = 2'd1, K_OVR = 2'd2, K_TMO = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_cmd_ready = 1'b0;
  logic        o_cmd_valid, o_cmd_wr, o_err_chk, o_err_overrun, o_err_timeout;
  logic [6:0]  o_cmd_addr;
  logic [15:0] o_cmd_wdata;
  logic [2:0]  o_dbg_state;

  uart_cmd_parser #(.SOF_BYTE(8'h55), .CLOCK_FREQ(50_000_000), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_wr(o_cmd_wr),
    .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata), .o_err_chk(o_err_chk),
    .o_err_overrun(o_err_overrun), .o_err_timeout(o_err_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  int          exp_e_q[$];
  logic [1:0]  err_k_q[$];
  int          err_e_q[$];

  logic [7:0] fq[$];
  int  last_e = 0;
  bit  pend = 1'b0;
  int  pend_chk = 0;
  int  pend_rel = 0;
  bit  mon_en = 1'b0;
  bit  head_seen = 1'b0;
  bit  acc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  task automatic model_byte(input logic [7:0] b, input int e);
    int sum;
    if (pend && e > pend_rel) pend = 1'b0;
    if (pend) begin
      err_k_q.push_back(K_OVR); err_e_q.push_back(e);
      return;
    end
    if (fq.size() == 0) begin
      if (b == 8'h55) begin fq.push_back(b); last_e = e; end
      return;
    end
    fq.push_back(b);
    last_e = e;
    if (fq.size() == 5) begin
      sum = (int'(fq[1]) + int'(fq[2]) + int'(fq[3])) % 256;
      if (int'(fq[4]) == sum) begin
        exp_q.push_back({fq[1], fq[2], fq[3]});
        exp_e_q.push_back(e);
        pend = 1'b1;
        pend_chk = e;
        pend_rel = i_cmd_ready ? e + 1 : INF;
      end else begin
        err_k_q.push_back(K_CHK); err_e_q.push_back(e);
      end
      fq.delete();
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send(input logic [7:0] b);
    int e;
    e = cyc + 1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    model_byte(b, e);
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (TMO_ON && fq.size() > 0 && last_e + T <= cyc + n) begin
      err_k_q.push_back(K_TMO); err_e_q.push_back(last_e + T);
      fq.delete();
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input bit v);
    if (!v && pend && pend_rel > cyc) return;
    i_cmd_ready = v;
    if (v && pend && pend_rel == INF) pend_rel = (cyc + 1 > pend_chk + 1) ? cyc + 1 : pend_chk + 1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k);
    send(8'h55); send(c); send(h); send(l); send(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_cmd_valid, 0);
    check({tag, "_wr"}, o_cmd_wr, 0);
    check({tag, "_addr"}, o_cmd_addr, 0);
    check({tag, "_wdata"}, o_cmd_wdata, 0);
    check({tag, "_errs"}, {o_err_chk, o_err_overrun, o_err_timeout}, 0);
    check({tag, "_state_hunt"}, o_dbg_state, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    i_rx_valid = 1'b0;
    #2;
    check_reset_outputs("rst");
    fq.delete(); exp_q.delete(); exp_e_q.delete(); err_k_q.delete(); err_e_q.delete();
    pend = 1'b0; head_seen = 1'b0; acc_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic pop_err(input logic [1:0] k);
    if (err_k_q.size() == 0) begin
      check("unexpected_err_pulse", k, 0);
    end else begin
      check("err_kind", k, err_k_q[0]);
      check("err_cycle", cyc, err_e_q[0]);
      void'(err_k_q.pop_front()); void'(err_e_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && mon_en) begin
      if (acc_prev) begin
        check("valid_drop_after_accept", o_cmd_valid, 0);
        acc_prev = 1'b0;
      end else if (o_cmd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          check("cmd_fields", {o_cmd_wr, o_cmd_addr, o_cmd_wdata}, exp_q[0]);
          if (!head_seen) begin
            check("cmd_latency", cyc, exp_e_q[0]);
            head_seen = 1'b1;
          end
          if (i_cmd_ready) begin
            void'(exp_q.pop_front()); void'(exp_e_q.pop_front());
            head_seen = 1'b0;
            acc_prev = 1'b1;
          end
        end
      end
      if (o_err_overrun) pop_err(K_OVR);
      if (o_err_chk)     pop_err(K_CHK);
      if (o_err_timeout) pop_err(K_TMO);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    set_ready(1'b1);
    idle(2);

    // write, bad checksum then good frame, garbage before SOF
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7); idle(3);
    send_frame(8'h81, 8'h12, 8'h34, 8'h00); idle(2);
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7); idle(2);
    send(8'h00); send(8'hFF); send(8'hAA);
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7); idle(3);
    // bad checksum equal to SOF must not start a new frame
    send_frame(8'h01, 8'h02, 8'h03, 8'h55); send(8'h81); send(8'h12); idle(2);
    // SOF value inside the frame is data
    send_frame(8'h55, 8'h55, 8'h55, 8'hFF); idle(3);

    // read under backpressure
    set_ready(1'b0);
    send_frame(8'h05, 8'h00, 8'h00, 8'h05);
    idle(20);
    set_ready(1'b1);
    idle(3);

    // overrun while pending, and a byte on the accepting cycle
    set_ready(1'b0);
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7);
    idle(2); send(8'h55); idle(2);
    set_ready(1'b1); send(8'h55); idle(2);
    send_frame(8'h2A, 8'hBE, 8'hEF, 8'h97); send(8'h33); idle(3);

    // inter-byte gap boundaries: exactly T survives, T+1 expires
    send(8'h55); send(8'h81); idle(150);
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7); idle(3);
    send(8'h55); idle(T - 1); send(8'h81); idle(T - 1); send(8'h12); idle(T); idle(2);
    send_frame(8'h7F, 8'h01, 8'h02, 8'h82); idle(3);

    // reset mid-frame and mid-issue
    send(8'h55); send(8'h81); send(8'h12);
    do_reset();
    set_ready(1'b1);
    idle(2);
    send_frame(8'h81, 8'h12, 8'h34, 8'hC7); idle(3);
    set_ready(1'b0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h66); idle(3);
    do_reset();
    set_ready(1'b1);
    idle(2);

    // randomized frames, garbage, corrupt checksums, backpressure and long gaps
    for (int f = 0; f < 80; f++) begin
      logic [7:0] fb[5];
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) set_ready(1'b0); else set_ready(1'b1);
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      fb[0] = 8'h55;
      fb[1] = 8'($urandom_range(0, 255));
      fb[2] = 8'($urandom_range(0, 255));
      fb[3] = 8'($urandom_range(0, 255));
      fb[4] = fb[1] + fb[2] + fb[3];
      if ($urandom_range(0, 4) == 0) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
      for (int i = 0; i < 5; i++) begin
        send(fb[i]);
        if ($urandom_range(0, 24) == 0) idle(T + $urandom_range(0, 20));
        else idle($urandom_range(0, 2));
      end
      if (i_cmd_ready == 1'b0) begin
        idle($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 0) send(8'($urandom_range(0, 255)));
        set_ready(1'b1);
      end
      idle($urandom_range(0, 3));
    end
    set_ready(1'b1);
    idle(T + 20);

    check("cmd_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_k_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
